// File: rtl/sram_program_loader_if.sv
// sram_program_loader_if: byte-stream handshake plus SRAM write bus driven by the loader
interface sram_program_loader_if #(parameter int ADDR_W = 18);
  logic [7:0] byte_data;
  logic byte_valid;
  logic byte_ready;
  logic sram_we;
  logic sram_ce;
  logic sram_oe;
  logic sram_lb;
  logic sram_ub;
  logic [ADDR_W-1:0] sram_a;
  logic [15:0] sram_d_out;
  logic sram_d_drive;
  modport master (
    input byte_data, byte_valid,
    output byte_ready, sram_we, sram_ce, sram_oe, sram_lb, sram_ub, sram_a, sram_d_out, sram_d_drive
  );
  modport slave (
    output byte_data, byte_valid,
    input byte_ready, sram_we, sram_ce, sram_oe, sram_lb, sram_ub, sram_a, sram_d_out, sram_d_drive
  );
endinterface

// File: rtl/sram_program_loader.sv
// sram_program_loader: packs host byte pairs into 16-bit words and writes them to SRAM from address 0.
// Optional checksum output enabled by defining SRAM_LOADER_CHECKSUM_EN.
module sram_program_loader #(
  parameter int ADDR_W = 18,
  parameter int WE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  sram_program_loader_if.master bus,
  output logic busy_o,
  output logic done_o,
  output logic overflow_o,
  // one bit wider than the address so a completely filled memory reports 2**ADDR_W words
  output logic [ADDR_W:0] word_count_o
`ifdef SRAM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] checksum_o
`endif
);
  typedef enum logic [2:0] {OFF, GET_HI, GET_LO, SETUP, PULSE, HOLD, FIN} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] hi_q, hi_d;
  logic [15:0] dout_q, dout_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic rdy_q, rdy_d, busy_q, busy_d, we_q, we_d, ce_q, ce_d;
  logic drv_q, drv_d, done_q, done_d, ovf_q, ovf_d;
  logic xfer, end_word, stop, hold_exit;
`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [15:0] chk_q, chk_d;
  assign checksum_o = chk_q;
`endif
  assign xfer = bus.byte_valid && rdy_q && !start_i;
  assign end_word = dout_q[15:12] == 4'd0;
  assign stop = end_word || &addr_q;
  assign hold_exit = state_q == HOLD && !start_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      cnt_q <= '0;
      hi_q <= '0;
      dout_q <= '0;
      addr_q <= '0;
      wc_q <= '0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
      we_q <= 1'b1;
      ce_q <= 1'b1;
      drv_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef SRAM_LOADER_CHECKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hi_q <= hi_d;
      dout_q <= dout_d;
      addr_q <= addr_d;
      wc_q <= wc_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
      we_q <= we_d;
      ce_q <= ce_d;
      drv_q <= drv_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
`ifdef SRAM_LOADER_CHECKSUM_EN
      chk_q <= chk_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      GET_HI: state_d = xfer ? GET_LO : GET_HI;
      GET_LO: state_d = xfer ? SETUP : GET_LO;
      SETUP:  state_d = PULSE;
      PULSE:  state_d = cnt_q == 4'(WE_CYCLES - 1) ? HOLD : PULSE;
      HOLD:   state_d = stop ? FIN : GET_HI;
      default: state_d = state_q;
    endcase
    if (start_i) state_d = GET_HI;
  end
  // registered outputs are computed from the next state so they line up with state_q
  always_comb begin
    rdy_d = state_d == GET_HI || state_d == GET_LO;
    busy_d = state_d != OFF && state_d != FIN;
    ce_d = !busy_d;
    we_d = state_d != PULSE;
    drv_d = state_d == SETUP || state_d == PULSE || state_d == HOLD;
    done_d = state_d == FIN;
    cnt_d = state_q == PULSE ? cnt_q + 4'd1 : 4'd0;
    hi_d = (state_q == GET_HI && xfer) ? bus.byte_data : hi_q;
    dout_d = (state_q == GET_LO && xfer) ? {hi_q, bus.byte_data} : dout_q;
    wc_d = start_i ? '0 : hold_exit ? wc_q + 1'b1 : wc_q;
    addr_d = start_i ? '0 : (hold_exit && !stop) ? addr_q + 1'b1 : addr_q;
    ovf_d = start_i ? 1'b0 : (hold_exit && !end_word && &addr_q) ? 1'b1 : ovf_q;
`ifdef SRAM_LOADER_CHECKSUM_EN
    chk_d = start_i ? '0 : hold_exit ? chk_q ^ dout_q : chk_q;
`endif
  end
  assign bus.byte_ready = rdy_q;
  assign bus.sram_we = we_q;
  assign bus.sram_ce = ce_q;
  assign bus.sram_oe = 1'b1;
  assign bus.sram_lb = 1'b0;
  assign bus.sram_ub = 1'b0;
  assign bus.sram_a = addr_q;
  assign bus.sram_d_out = dout_q;
  assign bus.sram_d_drive = drv_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign overflow_o = ovf_q;
  assign word_count_o = wc_q;
endmodule

// File: tb/tb_sram_program_loader.sv
// tb_sram_program_loader: random and directed loads checked against a word-list model of the loader
module tb_sram_program_loader;
  localparam int AW = 3;
  localparam int WEC = 3;
  typedef logic [7:0] bq_t[$];
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic busy, done, ovf;
  logic [AW:0] wc;
  int n_cmp = 0, n_bad = 0;
  logic [AW+15:0] wr_q[$], exp_wr[$];
  int len_q[$];
  int viol = 0, low_n = 0, exp_wc, exp_bytes;
  bit exp_ovf;
  logic [15:0] exp_chk, cap_d;
  logic [AW-1:0] cap_a;
`ifdef SRAM_LOADER_CHECKSUM_EN
  logic [15:0] chk;
`endif
  sram_program_loader_if #(.ADDR_W(AW)) bus ();
  sram_program_loader #(.ADDR_W(AW), .WE_CYCLES(WEC)) dut (
    .clk(clk), .rst(rst), .start_i(start), .bus(bus),
    .busy_o(busy), .done_o(done), .overflow_o(ovf), .word_count_o(wc)
`ifdef SRAM_LOADER_CHECKSUM_EN
    , .checksum_o(chk)
`endif
  );
  always #10 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end
  // bus monitor: records each completed write and audits the write-strobe rules
  always @(negedge clk) begin
    if (rst) low_n = 0;
    else begin
      if (bus.sram_d_drive && bus.byte_ready) viol++;
      if (!busy && (bus.sram_we !== 1'b1 || bus.sram_d_drive !== 1'b0 || bus.sram_ce !== 1'b1)) viol++;
      if (bus.sram_we === 1'b0) begin
        if (low_n == 0) begin cap_a = bus.sram_a; cap_d = bus.sram_d_out; end
        else if (bus.sram_a !== cap_a || bus.sram_d_out !== cap_d) viol++;
        if (!bus.sram_d_drive || bus.sram_ce) viol++;
        low_n++;
      end else if (low_n > 0) begin
        if (bus.sram_d_drive && (bus.sram_a !== cap_a || bus.sram_d_out !== cap_d)) viol++;
        wr_q.push_back({cap_a, cap_d});
        len_q.push_back(low_n);
        low_n = 0;
      end
    end
  end
  task automatic model(input bq_t bs);
    logic [15:0] w;
    exp_wr.delete(); exp_wc = 0; exp_ovf = 0; exp_chk = '0; exp_bytes = 0;
    for (int i = 0; i + 1 < bs.size(); i += 2) begin
      w = {bs[i], bs[i+1]};
      exp_wr.push_back({AW'(exp_wc), w});
      exp_wc++; exp_chk ^= w; exp_bytes += 2;
      if (w[15:12] == 4'd0) break;
      if (exp_wc == (1 << AW)) begin exp_ovf = 1; break; end
    end
  endtask
  function automatic logic [15:0] rand_word(input bit is_end);
    logic [15:0] w;
    w = 16'($urandom);
    w[15:12] = is_end ? 4'd0 : 4'($urandom_range(15, 1));
    return w;
  endfunction
  function automatic bit wr_ok();
    if (wr_q.size() != exp_wr.size()) return 0;
    foreach (wr_q[i]) if (wr_q[i] !== exp_wr[i]) return 0;
    return 1;
  endfunction
  function automatic bit len_ok();
    foreach (len_q[i]) if (len_q[i] != WEC) return 0;
    return len_q.size() == wr_q.size();
  endfunction
  task automatic clear_mon();
    @(negedge clk);
    wr_q.delete(); len_q.delete(); viol = 0;
  endtask
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input bit keep);
    int n = 0;
    @(negedge clk); bus.byte_data = b; bus.byte_valid = 1'b1;
    while (!bus.byte_ready && n < 100) begin @(negedge clk); n++; end
    n_cmp++;
    if (!bus.byte_ready) begin
      n_bad++;
      $display("FAIL send_timeout byte=%h: byte_ready=%b, required 1", b, bus.byte_ready);
    end
    @(posedge clk); #1;
    if (!keep) bus.byte_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL done_timeout: done=%b, required 1", done); end
  endtask
  task automatic drive_load(input bq_t bs, input bit keep);
    model(bs);
    clear_mon();
    pulse_start();
    for (int i = 0; i < exp_bytes; i++) send(bs[i], keep);
    bus.byte_valid = 1'b0;
    wait_done();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if ({busy, done, ovf, bus.byte_ready} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: busy/done/ovf/ready=%b, required 0000", {busy, done, ovf, bus.byte_ready}); end
    if (wc !== '0) begin n_bad++; $display("FAIL reset_wc: %0d, required 0", wc); end
    if ({bus.sram_we, bus.sram_ce, bus.sram_oe, bus.sram_lb, bus.sram_ub} !== 5'b11100) begin n_bad++; $display("FAIL reset_ctl: we/ce/oe/lb/ub=%b, required 11100", {bus.sram_we, bus.sram_ce, bus.sram_oe, bus.sram_lb, bus.sram_ub}); end
    if (bus.sram_a !== '0 || bus.sram_d_out !== '0) begin n_bad++; $display("FAIL reset_bus: a=%h d=%h, required 0 0", bus.sram_a, bus.sram_d_out); end
    if (bus.sram_d_drive !== 1'b0) begin n_bad++; $display("FAIL reset_drive: %b, required 0", bus.sram_d_drive); end
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_example();
    bq_t bs = '{8'h81, 8'h23, 8'h10, 8'h60, 8'h00, 8'h00};
    drive_load(bs, 0);
    n_cmp += 5;
    if (!wr_ok()) begin n_bad++; $display("FAIL example_writes: %0d writes last=%h, required %0d last=%h", wr_q.size(), wr_q.size() ? wr_q[$] : '0, exp_wr.size(), exp_wr[$]); end
    if (wc !== 4'd3) begin n_bad++; $display("FAIL example_wc: %0d, required 3", wc); end
    if ({ovf, busy} !== 2'b00) begin n_bad++; $display("FAIL example_ovf_busy: %b, required 00", {ovf, busy}); end
    if (!len_ok()) begin n_bad++; $display("FAIL example_we_len: first=%0d, required %0d", len_q.size() ? len_q[0] : -1, WEC); end
    if (viol != 0) begin n_bad++; $display("FAIL example_bus_rules: %0d violations, required 0", viol); end
`ifdef SRAM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (chk !== 16'h9143) begin n_bad++; $display("FAIL example_checksum: %h, required 9143", chk); end
`endif
  endtask
  task automatic test_latency();
    int n = 0;
    clear_mon();
    pulse_start();
    send(8'h9A, 0);
    send(8'hBC, 0);
    n_cmp += 3;
    if ({bus.sram_we, bus.sram_d_drive, bus.byte_ready, bus.sram_d_out} !== {3'b110, 16'h9ABC}) begin n_bad++; $display("FAIL setup_state: we/drv/rdy=%b d=%h, required 110 9abc", {bus.sram_we, bus.sram_d_drive, bus.byte_ready}, bus.sram_d_out); end
    while (!bus.byte_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n != WEC + 2) begin n_bad++; $display("FAIL ready_latency: %0d cycles, required %0d", n, WEC + 2); end
    if (len_q.size() != 1 || len_q[0] != WEC) begin n_bad++; $display("FAIL we_pulse_len: n=%0d len=%0d, required 1 %0d", len_q.size(), len_q.size() ? len_q[0] : -1, WEC); end
  endtask
  task automatic test_random_loads(input int iters, input bit keep);
    bq_t bs;
    logic [15:0] w;
    for (int k = 0; k < iters; k++) begin
      bs.delete();
      for (int i = 0; i < 10; i++) begin
        w = rand_word($urandom_range(3, 0) == 0);
        bs.push_back(w[15:8]); bs.push_back(w[7:0]);
      end
      drive_load(bs, keep);
      n_cmp += 6;
      if (!wr_ok()) begin n_bad++; $display("FAIL rand_writes keep=%0d: %0d writes, required %0d", keep, wr_q.size(), exp_wr.size()); end
      if (wc !== (AW+1)'(exp_wc)) begin n_bad++; $display("FAIL rand_wc: %0d, required %0d", wc, exp_wc); end
      if (ovf !== exp_ovf) begin n_bad++; $display("FAIL rand_ovf: %b, required %b", ovf, exp_ovf); end
      if (bus.sram_a !== AW'(exp_wc - 1)) begin n_bad++; $display("FAIL rand_last_addr: %0d, required %0d", bus.sram_a, exp_wc - 1); end
      if (!len_ok()) begin n_bad++; $display("FAIL rand_we_len: bad pulse length, required %0d", WEC); end
      if (viol != 0) begin n_bad++; $display("FAIL rand_bus_rules: %0d violations, required 0", viol); end
`ifdef SRAM_LOADER_CHECKSUM_EN
      n_cmp++;
      if (chk !== exp_chk) begin n_bad++; $display("FAIL rand_checksum: %h, required %h", chk, exp_chk); end
`endif
    end
  endtask
  task automatic test_overflow();
    bq_t bs;
    logic [15:0] w;
    for (int i = 0; i < 8; i++) begin
      w = rand_word(0);
      bs.push_back(w[15:8]); bs.push_back(w[7:0]);
    end
    drive_load(bs, 0);
    n_cmp += 3;
    if ({done, ovf} !== 2'b11) begin n_bad++; $display("FAIL ovf_flags: done/ovf=%b, required 11", {done, ovf}); end
    if (wc !== 4'd8 || bus.sram_a !== 3'd7) begin n_bad++; $display("FAIL ovf_count: wc=%0d a=%0d, required 8 7", wc, bus.sram_a); end
    if (!wr_ok()) begin n_bad++; $display("FAIL ovf_writes: %0d writes, required %0d", wr_q.size(), exp_wr.size()); end
  endtask
  task automatic test_restart();
    bq_t z = '{8'h00, 8'h00};
    int n = 0;
    pulse_start();
    send(8'h90, 0);
    drive_load(z, 0);
    n_cmp += 2;
    if (!wr_ok()) begin n_bad++; $display("FAIL restart_writes: %0d writes first=%h, required 1 first=%h", wr_q.size(), wr_q.size() ? wr_q[0] : '0, exp_wr[0]); end
    if (wc !== 4'd1) begin n_bad++; $display("FAIL restart_wc: %0d, required 1", wc); end
    clear_mon();
    pulse_start();
    @(negedge clk); bus.byte_data = 8'hAA; bus.byte_valid = 1'b1; start = 1'b1;
    @(negedge clk); bus.byte_valid = 1'b0; start = 1'b0;
    send(8'h00, 0); send(8'h00, 0);
    wait_done();
    n_cmp++;
    if (!wr_ok()) begin n_bad++; $display("FAIL start_wins: %0d writes first=%h, required 1 first=%h", wr_q.size(), wr_q.size() ? wr_q[0] : '0, exp_wr[0]); end
    pulse_start();
    send(8'h8F, 0); send(8'h01, 0);
    while (bus.sram_we && n < 20) begin @(negedge clk); n++; end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_cmp++;
    if ({bus.sram_we, bus.sram_d_drive, bus.byte_ready, busy} !== 4'b1011 || bus.sram_a !== '0) begin n_bad++; $display("FAIL abort_pulse: we/drv/rdy/busy=%b a=%0d, required 1011 0", {bus.sram_we, bus.sram_d_drive, bus.byte_ready, busy}, bus.sram_a); end
    repeat (2) @(negedge clk);
    wr_q.delete(); len_q.delete(); viol = 0;
    send(8'h00, 0); send(8'h00, 0);
    wait_done();
    n_cmp++;
    if (!wr_ok() || wc !== 4'd1) begin n_bad++; $display("FAIL abort_reload: %0d writes wc=%0d, required 1 1", wr_q.size(), wc); end
  endtask
  task automatic test_rst_mid_pulse();
    int n = 0;
    pulse_start();
    send(8'h81, 0); send(8'h23, 0);
    while (bus.sram_we && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({bus.sram_we, busy, bus.sram_d_drive} !== 3'b100) begin n_bad++; $display("FAIL rst_mid_pulse: we/busy/drv=%b, required 100", {bus.sram_we, busy, bus.sram_d_drive}); end
    @(negedge clk); rst = 1'b0;
  endtask
  initial begin
    bus.byte_data = '0; bus.byte_valid = 1'b0;
    test_reset();
    test_example();
    test_latency();
    test_random_loads(4, 0);
    test_random_loads(4, 1);
    test_overflow();
    test_restart();
    test_rst_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
